vga_scan_ctrl: RTL and testbench



---
 rtl/vga_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_vga_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA pixel-scan timing generator for the pong display path.
// Produces hsync/vsync, the visible-area flag, pixel coordinates, a
// frame_start pulse and a frame-aligned move_tick every MOVE_DIV frames.
// Optional feature: define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_scan_ctrl #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int MOVE_DIV  = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        move_en,
    output logic        hsync,
    output logic        vsync,
    output logic        video_en,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        frame_start,
`ifdef VGA_FRAME_CNT_EN
    output logic [15:0] frame_cnt,
`endif
    output logic        move_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS       = 12'(H_VISIBLE);
    localparam logic [11:0] V_VIS       = 12'(V_VISIBLE);
    localparam logic [11:0] H_SYNC_BEG  = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] H_SYNC_END  = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [11:0] V_SYNC_BEG  = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] V_SYNC_END  = 12'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [7:0]  DIV_LAST    = 8'(MOVE_DIV - 1);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [7:0]  div_cnt;
    logic        tick_pend;
    logic        eof;

    // End of frame: last pixel of the last line.
    always_comb begin
        eof = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end

    // Horizontal and vertical scan counters.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    // Frame divider sampled at EOF; tick_pend marks the (0,0) counter cycle
    // so move_tick is registered on the same edge as frame_start.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt   <= '0;
            tick_pend <= 1'b0;
        end else if (eof) begin
            if (!move_en) begin
                div_cnt   <= '0;
                tick_pend <= 1'b0;
            end else if (div_cnt == DIV_LAST) begin
                div_cnt   <= '0;
                tick_pend <= 1'b1;
            end else begin
                div_cnt   <= div_cnt + 8'd1;
                tick_pend <= 1'b0;
            end
        end else begin
            tick_pend <= 1'b0;
        end
    end

    // Registered video outputs derived from the current counter values.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_en    <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            move_tick   <= 1'b0;
        end else begin
            hsync       <= !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
            vsync       <= !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
            video_en    <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
            pix_x       <= ((h_cnt < H_VIS) && (v_cnt < V_VIS)) ? h_cnt : '0;
            pix_y       <= ((h_cnt < H_VIS) && (v_cnt < V_VIS)) ? v_cnt : '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            move_tick   <= tick_pend;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic eof_pend;

    // Frame counter advances on the edge that raises frame_start after an EOF.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            eof_pend  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            eof_pend <= eof;
            if (eof_pend) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl: two small-timing instances (MOVE_DIV=3
// and MOVE_DIV=1) checked cycle by cycle against an arithmetic reference model.
module tb_vga_scan_ctrl;

    // Instance 0: H 8/2/2/2, V 6/1/1/1, MOVE_DIV=3
    localparam int A_HV = 8,  A_HF = 2, A_HS = 2, A_HB = 2;
    localparam int A_VV = 6,  A_VF = 1, A_VS = 1, A_VB = 1;
    localparam int A_DIV = 3;
    // Instance 1: H 10/3/5/4, V 7/2/2/3, MOVE_DIV=1
    localparam int B_HV = 10, B_HF = 3, B_HS = 5, B_HB = 4;
    localparam int B_VV = 7,  B_VF = 2, B_VS = 2, B_VB = 3;
    localparam int B_DIV = 1;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        ve;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
        logic        mt;
        logic [15:0] fc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic move_en;

    logic hs0, vs0, ve0, fs0, mt0;
    logic [11:0] x0, y0;
    logic hs1, vs1, ve1, fs1, mt1;
    logic [11:0] x1, y1;
    logic [15:0] fc0, fc1;

    int compared;
    int mismatched;

    exp_t q0[$];
    exp_t q1[$];
    int   n0, n1;   // counter-state index since reset
    int   c0, c1;   // enabled EOFs seen since last tick
    bit   p0, p1;   // tick due with the current state's outputs

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_scan_ctrl #(
        .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
        .MOVE_DIV(A_DIV)
    ) dut0 (
        .vga_clk(clk), .sys_rst_n(rst_n), .move_en(move_en),
        .hsync(hs0), .vsync(vs0), .video_en(ve0),
        .pix_x(x0), .pix_y(y0), .frame_start(fs0),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt(fc0),
`endif
        .move_tick(mt0)
    );

    vga_scan_ctrl #(
        .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .MOVE_DIV(B_DIV)
    ) dut1 (
        .vga_clk(clk), .sys_rst_n(rst_n), .move_en(move_en),
        .hsync(hs1), .vsync(vs1), .video_en(ve1),
        .pix_x(x1), .pix_y(y1), .frame_start(fs1),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt(fc1),
`endif
        .move_tick(mt1)
    );

`ifndef VGA_FRAME_CNT_EN
    assign fc0 = '0;
    assign fc1 = '0;
`endif

    function automatic int htot(input int i);
        return (i == 0) ? (A_HV + A_HF + A_HS + A_HB) : (B_HV + B_HF + B_HS + B_HB);
    endfunction

    function automatic int vtot(input int i);
        return (i == 0) ? (A_VV + A_VF + A_VS + A_VB) : (B_VV + B_VF + B_VS + B_VB);
    endfunction

    // Expected outputs following an edge taken in scan state n.
    function automatic exp_t model_out(input int i, input int n, input bit pend);
        exp_t e;
        int ht, vt, h, v, hv, vv, hsb, hse, vsb, vse;
        ht  = htot(i);
        vt  = vtot(i);
        h   = n % ht;
        v   = (n / ht) % vt;
        hv  = (i == 0) ? A_HV : B_HV;
        vv  = (i == 0) ? A_VV : B_VV;
        hsb = (i == 0) ? (A_HV + A_HF) : (B_HV + B_HF);
        hse = hsb + ((i == 0) ? A_HS : B_HS);
        vsb = (i == 0) ? (A_VV + A_VF) : (B_VV + B_VF);
        vse = vsb + ((i == 0) ? A_VS : B_VS);
        e.hs = !(h >= hsb && h < hse);
        e.vs = !(v >= vsb && v < vse);
        e.ve = (h < hv) && (v < vv);
        e.x  = e.ve ? 12'(h) : 12'd0;
        e.y  = e.ve ? 12'(v) : 12'd0;
        e.fs = (h == 0) && (v == 0);
        e.mt = pend;
`ifdef VGA_FRAME_CNT_EN
        e.fc = 16'((n / (ht * vt)) % 65536);
`else
        e.fc = 16'd0;
`endif
        return e;
    endfunction

    // Advance the divider model across one edge taken in scan state n.
    task automatic step(input int i, input int n, input int c, input bit en,
                        output int nc, output bit np);
        int div;
        div = (i == 0) ? A_DIV : B_DIV;
        nc  = c;
        np  = 1'b0;
        if (((n + 1) % (htot(i) * vtot(i))) == 0) begin
            if (en) begin
                nc = c + 1;
                if (nc == div) begin
                    nc = 0;
                    np = 1'b1;
                end
            end else begin
                nc = 0;
            end
        end
    endtask

    function automatic exp_t act(input int i);
        exp_t a;
        if (i == 0) begin
            a = '{hs: hs0, vs: vs0, ve: ve0, x: x0, y: y0, fs: fs0, mt: mt0, fc: fc0};
        end else begin
            a = '{hs: hs1, vs: vs1, ve: ve1, x: x1, y: y1, fs: fs1, mt: mt1, fc: fc1};
        end
        return a;
    endfunction

    task automatic check(input string name, input exp_t a, input exp_t e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s @%0t: got hs=%b vs=%b ve=%b x=%0d y=%0d fs=%b mt=%b fc=%0d, expected hs=%b vs=%b ve=%b x=%0d y=%0d fs=%b mt=%b fc=%0d",
                     name, $time, a.hs, a.vs, a.ve, a.x, a.y, a.fs, a.mt, a.fc,
                     e.hs, e.vs, e.ve, e.x, e.y, e.fs, e.mt, e.fc);
        end
    endtask

    // Reference model: push the expected response for every edge taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n0 = 0; c0 = 0; p0 = 1'b0; q0.delete();
            n1 = 0; c1 = 0; p1 = 1'b0; q1.delete();
        end else begin
            int nc;
            bit np;
            q0.push_back(model_out(0, n0, p0));
            q1.push_back(model_out(1, n1, p1));
            step(0, n0, c0, move_en, nc, np); c0 = nc; p0 = np; n0++;
            step(1, n1, c1, move_en, nc, np); c1 = nc; p1 = np; n1++;
        end
    end

    // Monitor: pop and compare whenever the DUT has presented a new output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q0.size() > 0) check("scan0", act(0), q0.pop_front());
            if (q1.size() > 0) check("scan1", act(1), q1.pop_front());
        end
    end

    task automatic check_reset();
        exp_t r;
        r = '{hs: 1'b1, vs: 1'b1, ve: 1'b0, x: 12'd0, y: 12'd0, fs: 1'b0, mt: 1'b0, fc: 16'd0};
        check("reset0", act(0), r);
        check("reset1", act(1), r);
    endtask

    task automatic run_random(input int cycles, input int toggle_odds);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(toggle_odds - 1, 0) == 0) move_en = ~move_en;
        end
    endtask

    initial begin
        int tries;
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        move_en    = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check_reset();
        rst_n = 1'b1;

        // Disabled: no ticks across several frames
        repeat (700) @(negedge clk);
        // Enabled continuously
        #1 move_en = 1'b1;
        repeat (1500) @(negedge clk);
        // Random mid-frame toggles
        run_random(3000, 150);

        // Asynchronous reset mid-line at h_cnt=5 of instance 0
        tries = 0;
        do begin
            @(negedge clk);
            tries++;
        end while ((n0 % htot(0)) != 5 && tries < 500);
        if ((n0 % htot(0)) != 5) begin
            mismatched++;
            compared++;
            $display("FAIL reset_align: h state %0d, required 5", n0 % htot(0));
        end
        #2 rst_n = 1'b0;
        #1 check_reset();
        @(negedge clk);
        #1 check_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        move_en = 1'b1;

        run_random(2000, 120);
        move_en = 1'b1;
        repeat (600) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
